alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Execute-stage front end that sits directly upstream of the ALU. It selects ALU operands from register-file data, PC, immediate and constants.
- It applies a one-source forwarding bypass and registers the selected operation into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Its outputs drive the ALU's a_i, b_i and alu_op_i inputs plus the destination tag that travels alongside. Opcodes are the alu_opcodes_pkg values, passed through unchanged.

Parameters:
- XLEN, 32, operand/result width.
- RADDR_W, 5, register address width.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous discard of all buffered entries
- valid_i  in  1  upstream request valid
- ready_o  out  1  stage can accept this cycle
- rs1_data_i  in  XLEN  register-file read data 1
- rs2_data_i  in  XLEN  register-file read data 2
- rs1_addr_i  in  RADDR_W  source 1 address
- rs2_addr_i  in  RADDR_W  source 2 address
- imm_i  in  XLEN  sign-extended immediate
- pc_i  in  XLEN  instruction PC
- a_sel_i  in  2  0 = rs1, 1 = pc, 2 = zero, 3 = zero
- b_sel_i  in  2  0 = rs2, 1 = imm, 2 = constant 4, 3 = zero
- alu_op_i  in  5  ALU operation code
- rd_addr_i  in  RADDR_W  destination register
- rd_we_i  in  1  destination write enable
- fwd_we_i  in  1  forwarding source valid (ALU writeback)
- fwd_addr_i  in  RADDR_W  forwarding destination address
- fwd_data_i  in  XLEN  forwarding data
- valid_o  out  1  output entry valid
- ready_i  in  1  downstream accepts
- alu_a_o  out  XLEN  operand A to ALU
- alu_b_o  out  XLEN  operand B to ALU
- alu_op_o  out  5  operation to ALU
- rd_addr_o  out  RADDR_W  destination tag
- rd_we_o  out  1  destination write enable

Behaviour:
- Reset (rst_ni low, asynchronous):
  - valid_o = 0; skid entry invalid; ready_o = 1.
  - alu_a_o, alu_b_o, alu_op_o, rd_addr_o and rd_we_o all = 0.
  - Release is synchronous to clk_i.
- Operand selection (combinational, at capture time):
  - rs1 value = fwd_data_i if fwd_we_i && fwd_addr_i == rs1_addr_i && rs1_addr_i != 0; otherwise rs1_data_i. rs2 uses the same rule.
  - Forwarding applies only at capture. Held entries are not updated.
  - A = {rs1, pc_i, 0, 0}[a_sel_i]; B = {rs2, imm_i, 32'd4, 0}[b_sel_i].
- Handshakes:
  - Accept when valid_i && ready_o. Pop when valid_o && ready_i.
  - Output payload is stable while valid_o && !ready_i.
- Storage: two entries, an output register (O) and a skid register (S).
  - ready_o = !S.valid, driven from a register with no combinational path from ready_i.
- States:
  - EMPTY: O and S invalid.
  - ONE: O valid.
  - FULL: O and S valid.
- Transitions:
  - EMPTY + accept -> ONE; the entry appears on the outputs the cycle after capture (latency 1).
  - ONE + accept + pop -> ONE, new entry in O.
  - ONE + accept, no pop -> FULL, new entry in S.
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE, S moves to O. No accept is possible because ready_o = 0.
  - FULL, no pop -> FULL, hold.
- Ordering is strictly FIFO. No entry is duplicated or dropped.
- flush_i:
  - Next cycle O and S are invalid and ready_o = 1.
  - An accept in the flush cycle is discarded. Flush has priority over accept and pop.
  - Payload registers may keep stale data; valid_o = 0 is the only guarantee.
- Payload registers load only on capture or S->O move. No arithmetic is done in this stage.
- rd_we_o is meaningful only when valid_o = 1.

Test Plan:
- Reset then single op: rs1_addr = 3, rs1_data = 10, rs2_data = 7, a_sel = 0, b_sel = 0, alu_op = ALU_SUB, valid_i one cycle -> next cycle valid_o = 1, alu_a_o = 10, alu_b_o = 7, alu_op_o = ALU_SUB.
- Selection: a_sel = 1, pc = 0x100, b_sel = 2 -> alu_a_o = 0x100, alu_b_o = 4. Then b_sel = 1, imm = 0xFFFFFFF0 -> alu_b_o = 0xFFFFFFF0.
- Forwarding: fwd_we = 1, fwd_addr = 5, fwd_data = 0xDEAD, rs2_addr = 5, rs2_data = 1 -> alu_b_o = 0xDEAD. Same with rs1_addr = 0, fwd_addr = 0 -> alu_a_o = rs1_data.
- Backpressure: ready_i = 0, push A then B -> ready_o = 0 after B and A held stable. Raise ready_i -> A then B in order, then ready_o = 1.
- Flush while FULL (ready_i = 0) with valid_i = 1 -> next cycle valid_o = 0, ready_o = 1, nothing emitted later.
- Async reset asserted mid-transfer between clock edges -> valid_o = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: execute-stage front end ahead of the ALU.
// Picks the A/B operands from register data, PC, immediate or constants.
// A single writeback source may override the register-file data.
// The selected operation then goes into a two-entry skid buffer with
// valid/ready handshakes on both sides. Nothing is computed here; the
// opcode and destination tag travel with the operands unchanged.
module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [RADDR_W-1:0] rs1_addr_i,
  input  logic [RADDR_W-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [1:0]         a_sel_i,
  input  logic [1:0]         b_sel_i,
  input  logic [4:0]         alu_op_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               rd_we_i,
  input  logic               fwd_we_i,
  input  logic [RADDR_W-1:0] fwd_addr_i,
  input  logic [XLEN-1:0]    fwd_data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    alu_a_o,
  output logic [XLEN-1:0]    alu_b_o,
  output logic [4:0]         alu_op_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               rd_we_o
);

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [4:0]         op;
    logic [RADDR_W-1:0] rd;
    logic               we;
  } entry_t;

  // EMPTY: nothing held; ONE: output entry valid; FULL: output and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t entry_p0;
  entry_t out_p1;
  entry_t skid_p1;
  logic   load_out;
  logic   load_skid;
  logic   move_skid;
  logic   accept;
  logic   pop;

  // Register x0 is hard-wired zero, so a writeback to it is never forwarded.
  function automatic logic [XLEN-1:0] bypass(input logic [XLEN-1:0]    rf_data,
                                              input logic [RADDR_W-1:0] src_addr);
    if (fwd_we_i && (fwd_addr_i == src_addr) && (src_addr != '0))
      return fwd_data_i;
    return rf_data;
  endfunction

  // Both handshake outputs decode the state register only, so ready_o has
  // no combinational dependence on ready_i.
  assign ready_o = (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign accept  = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  assign alu_a_o   = out_p1.a;
  assign alu_b_o   = out_p1.b;
  assign alu_op_o  = out_p1.op;
  assign rd_addr_o = out_p1.rd;
  assign rd_we_o   = out_p1.we;

  // ---- p0: operand selection with bypass, evaluated at capture time ----
  // Build the candidate entry from the current request.
  always_comb begin
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    rs1_val = bypass(rs1_data_i, rs1_addr_i);
    rs2_val = bypass(rs2_data_i, rs2_addr_i);
    entry_p0 = '0;
    unique case (a_sel_i)
      2'd0:    entry_p0.a = rs1_val;
      2'd1:    entry_p0.a = pc_i;
      default: entry_p0.a = '0;
    endcase
    unique case (b_sel_i)
      2'd0:    entry_p0.b = rs2_val;
      2'd1:    entry_p0.b = imm_i;
      2'd2:    entry_p0.b = XLEN'(4);
      default: entry_p0.b = '0;
    endcase
    entry_p0.op = alu_op_i;
    entry_p0.rd = rd_addr_i;
    entry_p0.we = rd_we_i;
  end

  // Next state and load strobes for the two buffer entries; flush wins.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            load_out = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // ---- p1: output and skid entries, loaded only on capture or skid move ----
  // Payload registers; outputs read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_p1  <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_out)       out_p1 <= entry_p0;
      else if (move_skid) out_p1 <= skid_p1;
      if (load_skid)      skid_p1 <= entry_p0;
    end
  end

endmodule
